// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS checker: FSM state encodings and default LFSR geometry.
// Encodings match the ones used by the generator side of the link and the benches.
package prbs_checker_pkg;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_TAP   = 1;

endpackage

// File: rtl/prbs_checker_history_reg.sv
// History shift register with selectable load (received bit or predicted bit) and the tap XOR
// that predicts the next bit. Optional dead-line flag under PRBS_CHK_ZERO_GUARD_EN.
module prbs_checker_history_reg #(
    parameter int WIDTH = 4,
    parameter int TAP   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sel_expected,
    input  logic bit_in,
    output logic expected,
    output logic dead
);

    logic [WIDTH-1:0] hist;
    logic             load_bit;

    assign expected = hist[TAP] ^ hist[0];
    assign load_bit = sel_expected ? expected : bit_in;

    // Newest bit enters at the top, oldest sits in bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
        end else if (en) begin
            hist <= {load_bit, hist[WIDTH-1:1]};
        end
    end

`ifdef PRBS_CHK_ZERO_GUARD_EN
    assign dead = (hist == '0);
`else
    assign dead = 1'b0;
`endif

endmodule

// File: rtl/prbs_checker.sv
// PRBS stream checker: self-synchronising HUNT/ACQ/LOCKED FSM with saturating error count.
// Build option PRBS_CHK_ZERO_GUARD_EN rejects an all-zero (dead) line.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TAP      = DEF_TAP,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_loss,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int LOSS_W  = $clog2(LOSS_CNT + 1);

    logic [1:0]         state_n;
    logic [FILL_W-1:0]  fill_cnt, fill_n;
    logic [MATCH_W-1:0] match_cnt, match_n;
    logic [LOSS_W-1:0]  cons_err, cons_n;
    logic               expected, dead, mismatch, acq_bad;
    logic               err_hit, loss_hit;

    prbs_checker_history_reg #(
        .WIDTH (WIDTH),
        .TAP   (TAP)
    ) u_hist (
        .clk          (clk),
        .rst          (rst),
        .en           (bit_valid),
        .sel_expected (state == ST_LOCKED),
        .bit_in       (bit_in),
        .expected     (expected),
        .dead         (dead)
    );

    assign mismatch = bit_in ^ expected;
    assign acq_bad  = mismatch | (dead & ~bit_in);

    always_comb begin
        state_n  = state;
        fill_n   = fill_cnt;
        match_n  = match_cnt;
        cons_n   = cons_err;
        err_hit  = 1'b0;
        loss_hit = 1'b0;
        if (bit_valid) begin
            case (state)
                ST_HUNT: begin
                    if (fill_cnt == FILL_W'(WIDTH - 1)) begin
                        state_n = ST_ACQ;
                        fill_n  = '0;
                        match_n = '0;
                    end else begin
                        fill_n = fill_cnt + FILL_W'(1);
                    end
                end
                ST_ACQ: begin
                    if (acq_bad) begin
                        match_n = '0;
                    end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                        state_n = ST_LOCKED;
                        match_n = '0;
                        cons_n  = '0;
                    end else begin
                        match_n = match_cnt + MATCH_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (mismatch) begin
                        err_hit = 1'b1;
                        cons_n  = cons_err + LOSS_W'(1);
                        if (cons_err == LOSS_W'(LOSS_CNT - 1)) begin
                            loss_hit = 1'b1;
                        end
                    end else begin
                        cons_n = '0;
                    end
                    // The feedback is nonsingular, so a zero history in LOCKED can only
                    // persist; checking the current value is the same as the next one.
                    if (dead) begin
                        loss_hit = 1'b1;
                    end
                    if (loss_hit) begin
                        state_n = ST_HUNT;
                        fill_n  = '0;
                        cons_n  = '0;
                    end
                end
                default: begin
                    state_n = ST_HUNT;
                    fill_n  = '0;
                    match_n = '0;
                    cons_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HUNT;
            fill_cnt  <= '0;
            match_cnt <= '0;
            cons_err  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            sync_loss <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            fill_cnt  <= fill_n;
            match_cnt <= match_n;
            cons_err  <= cons_n;
            locked    <= (state_n == ST_LOCKED);
            err_pulse <= err_hit;
            sync_loss <= loss_hit;
            // A clear coinciding with a counted error leaves that error on the count.
            if (clr_cnt) begin
                err_count <= err_hit ? CNT_W'(1) : '0;
            end else if (err_hit && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule
